// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frontend
// Purpose  : UART receive front end. It synchronises the serial line, frames
//            8-bit LSB-first bytes and holds them in a one-deep buffer that the
//            consumer drains with an ack pulse.
//            Optional macro UART_RX_PARITY_EN selects 8E1 framing (default 8N1).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_IDLE = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_PARITY    = 3'd5;
`endif

    localparam logic [15:0] c_HALF = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] c_LAST = 16'(CLKS_PER_BIT - 1);

    logic        r_sync;
    logic        r_rxs;
    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_sh;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        r_ovr;

    logic        w_sample;
    logic        w_commit;
    logic        w_err_set;
    logic        w_par_ok;

    // Resynchroniser idles high so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 1'b1;
            r_rxs  <= 1'b1;
        end else begin
            r_sync <= UART_RX;
            r_rxs  <= r_sync;
        end
    end

    assign w_sample = (r_cnt == c_LAST);

`ifdef UART_RX_PARITY_EN
    logic r_par_err;
    assign w_par_ok = ~r_par_err;
`else
    assign w_par_ok = 1'b1;
`endif

    always_comb begin
        w_commit  = 1'b0;
        w_err_set = 1'b0;
        case (r_state)
            c_STOP: begin
                if (w_sample) begin
                    w_commit  = r_rxs & w_par_ok;
                    w_err_set = ~r_rxs;
                end
            end
`ifdef UART_RX_PARITY_EN
            c_PARITY: begin
                if (w_sample && (r_rxs != ^r_sh)) begin
                    w_err_set = 1'b1;
                end
            end
`endif
            default: begin
                w_commit  = 1'b0;
                w_err_set = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_sh    <= 8'h00;
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= 16'd0;
                    if (!r_rxs) begin
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (r_cnt == c_HALF) begin
                        r_cnt   <= 16'd0;
                        r_idx   <= 3'd0;
                        r_state <= r_rxs ? c_IDLE : c_DATA;
`ifdef UART_RX_PARITY_EN
                        r_par_err <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_DATA: begin
                    if (w_sample) begin
                        r_cnt       <= 16'd0;
                        r_sh[r_idx] <= r_rxs;
                        if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= c_PARITY;
`else
                            r_state <= c_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_PARITY: begin
                    if (w_sample) begin
                        r_cnt     <= 16'd0;
                        r_par_err <= (r_rxs != ^r_sh);
                        r_state   <= c_STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`endif
                c_STOP: begin
                    if (w_sample) begin
                        r_cnt   <= 16'd0;
                        r_state <= r_rxs ? c_IDLE : c_WAIT_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_WAIT_IDLE: begin
                    r_cnt <= 16'd0;
                    if (r_rxs) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

    // Ack clears first; a commit or error in the same cycle then takes precedence.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (rx_ack) begin
                r_valid <= 1'b0;
                r_ferr  <= 1'b0;
                r_ovr   <= 1'b0;
            end
            if (w_commit) begin
                r_data  <= r_sh;
                r_valid <= 1'b1;
                if (r_valid && !rx_ack) begin
                    r_ovr <= 1'b1;
                end
            end
            if (w_err_set) begin
                r_ferr <= 1'b1;
            end
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_ferr;
    assign rx_overrun   = r_ovr;
    assign rx_busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frontend
// Purpose  : Directed plus randomized bench for uart_rx_frontend, checked
//            against a frame-level model of the receive buffer and its flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frontend;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Negedge index (from the start-bit drive) that precedes the commit edge:
    // 2 sync + 1 entry + HALF+1 start + 8 data bits + stop bit, one bit per CPB.
    localparam int COMMIT_C = 3 + HALF + (NBITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ferr;
    logic       m_ovr;

    uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .UART_RX      (uart_rx),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic busy_exp);
        chk({tag, "/data"},  rx_data,      m_data);
        chk({tag, "/valid"}, rx_valid,     m_valid);
        chk({tag, "/ferr"},  rx_frame_err, m_ferr);
        chk({tag, "/ovr"},   rx_overrun,   m_ovr);
        chk({tag, "/busy"},  rx_busy,      busy_exp);
    endtask

    task automatic m_reset();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic m_ack();
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Buffer outcome of one complete frame; ack_same means ack in its commit cycle.
    task automatic m_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                           input bit ack_same);
        bit was_pending;
        was_pending = m_valid && !ack_same;
        if (ack_same) m_ack();
        if (!stop_ok || !par_ok) begin
            m_ferr = 1'b1;
        end else begin
            if (was_pending) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data  = d;
        end
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        m_ack();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                              input int ack_at, input int rst_at);
        logic [NBITS-1:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]   = (^d) ^ par_flip;
`else
        if (par_flip) bits[0] = 1'b0;
`endif
        bits[NBITS-1] = stop;
        for (int c = 0; c < NBITS * CPB; c++) begin
            if (rst_at >= 0 && c == rst_at + 1) begin
                reset   = 1'b0;
                uart_rx = 1'b1;
                rx_ack  = 1'b0;
                break;
            end
            uart_rx = bits[c / CPB];
            rx_ack  = (c == ack_at);
            if (c == rst_at) reset = 1'b1;
            @(negedge clk);
        end
        rx_ack = 1'b0;
    endtask

    initial begin
        logic [39:0] stream;
        logic [7:0]  d;
        bit          bad;
        bit          ack_same;

        m_reset();
        repeat (3) @(negedge clk);
        check_all("reset_held", 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_all("reset_rel", 1'b0);

`ifndef UART_RX_PARITY_EN
        // Continuous 8N1 line stream carrying 0xCB then 0xFA.
        stream = 40'hffffa7ff96;
        for (int c = 0; c < 40 * CPB; c++) begin
            uart_rx = stream[c / CPB];
            if (c == 200) begin
                m_frame(8'hCB, 1'b1, 1'b1, 1'b0);
                check_all("stream1", 1'b0);
                rx_ack = 1'b1;
                m_ack();
            end
            if (c == 201) rx_ack = 1'b0;
            if (c == 202) chk("stream_ack/valid", rx_valid, 1'b0);
            @(negedge clk);
        end
        m_frame(8'hFA, 1'b1, 1'b1, 1'b0);
        check_all("stream2", 1'b0);
        ack_pulse();
`endif

        // Start-bit glitch shorter than half a bit.
        uart_rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_rx = 1'b1;
        chk("glitch/busy", rx_busy, 1'b1);
        idle(3 * CPB);
        check_all("glitch_end", 1'b0);

        // Framing error, break held low into WAIT_IDLE.
        send_frame(8'h55, 1'b0, 1'b0, -1, -1);
        m_frame(8'h55, 1'b0, 1'b1, 1'b0);
        check_all("frame_err", 1'b1);
        idle(6);
        check_all("frame_idle", 1'b0);
        ack_pulse();
        check_all("frame_ack", 1'b0);

        // Overrun: two bytes without ack.
        send_frame(8'h12, 1'b1, 1'b0, -1, -1);
        m_frame(8'h12, 1'b1, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0, -1, -1);
        m_frame(8'h34, 1'b1, 1'b1, 1'b0);
        check_all("overrun", 1'b0);
        ack_pulse();
        check_all("overrun_ack", 1'b0);

        // Ack lands exactly on the commit edge of the second byte.
        send_frame(8'h56, 1'b1, 1'b0, -1, -1);
        m_frame(8'h56, 1'b1, 1'b1, 1'b0);
        send_frame(8'h78, 1'b1, 1'b0, COMMIT_C, -1);
        m_frame(8'h78, 1'b1, 1'b1, 1'b1);
        check_all("ack_commit", 1'b0);
        ack_pulse();

        // Reset in the middle of data bit 4, with a byte still pending.
        send_frame(8'h9A, 1'b1, 1'b0, -1, -1);
        m_frame(8'h9A, 1'b1, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, -1, 5 * CPB + HALF);
        m_reset();
        check_all("mid_reset", 1'b0);
        idle(2 * CPB);
        send_frame(8'h3C, 1'b1, 1'b0, -1, -1);
        m_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        check_all("after_reset", 1'b0);
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        send_frame(8'hC3, 1'b1, 1'b1, -1, -1);
        m_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        check_all("parity_err", 1'b0);
        ack_pulse();
        check_all("parity_ack", 1'b0);
`endif

        // Randomized frames, gaps, acks and bad stop bits.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) ack_pulse();
            d        = 8'($urandom);
            bad      = ($urandom_range(7, 0) == 0);
            ack_same = !bad && ($urandom_range(3, 0) == 0);
            send_frame(d, !bad, 1'b0, ack_same ? COMMIT_C : -1, -1);
            m_frame(d, !bad, 1'b1, ack_same);
            check_all($sformatf("rand%0d", i), bad);
            if (bad) idle(4 + $urandom_range(CPB, 0));
            else     idle($urandom_range(CPB, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
